mic_capture: RTL and testbench

//   Upstream feeder for the signal-delay stage. Generates the audio sample rate and runs
//   one serial (SPI-mode-0) ADC conversion per sample. Frames the 12-bit result down to
//   D_WIDTH unsigned bits. Emits sample + a 1-cycle sample_valid, which drives the delay

---
 rtl/mic_pkg.sv | 19 +
 rtl/tick_gen.sv | 32 +++
 rtl/mic_capture.sv | 132 +++++++++++++
 tb/tb_mic_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared types and helpers for the microphone ADC capture block.
package mic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    DONE
  } state_e;

  localparam int ADC_BITS_DEF  = 12;
  localparam int LEAD_BITS_DEF = 2;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Enable-gated modulo-DIV counter; tick_o marks the last count of each period.
module tick_gen
  import mic_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = '0;
    if (en_i && (count_q != LAST)) count_d = count_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tick_o = (count_q == LAST);

endmodule

// File: rtl/mic_capture.sv
// Sample-rate generator plus SPI-mode-0 ADC reader; emits one framed sample per period.
module mic_capture
  import mic_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int ADC_BITS   = ADC_BITS_DEF,
  parameter int LEAD_BITS  = LEAD_BITS_DEF,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               adc_miso,
  output logic               adc_cs_n,
  output logic               adc_sclk,
  output logic [D_WIDTH-1:0] sample,
  output logic               sample_valid,
  output logic               busy
);

  localparam int N  = LEAD_BITS + ADC_BITS;
  localparam int HW = cnt_width(CLK_DIV);
  localparam int BW = cnt_width(N);

  if (D_WIDTH < 1 || D_WIDTH > ADC_BITS || ADC_BITS < 2) begin : g_bad_width
    $error("mic_capture: D_WIDTH must be in 1..ADC_BITS and ADC_BITS >= 2");
  end
  if (CLK_DIV < 1 || SAMPLE_DIV <= CLK_DIV * (2 * N + 1) + 2) begin : g_bad_rate
    $error("mic_capture: SAMPLE_DIV too small for one conversion");
  end

  state_e               state_q, state_d;
  logic [HW-1:0]        half_q, half_d;
  logic                 phase_q, phase_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [ADC_BITS-1:0]  shift_q, shift_d;
  logic [D_WIDTH-1:0]   sample_q, sample_d;
  logic                 cs_n_q, sclk_q, valid_q, busy_q;
  logic                 tick;
  logic                 half_last;

  tick_gen #(.DIV(SAMPLE_DIV)) u_rate (
    .clk    (clk),
    .rst_n  (rst),
    .en_i   (en),
    .tick_o (tick)
  );

  assign half_last = (half_q == HW'(CLK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CS_SETUP;
          half_d  = '0;
        end
      end
      CS_SETUP: begin
        if (half_last) begin
          state_d = SHIFT;
          half_d  = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      SHIFT: begin
        // First cycle of a high phase is the edge that raises adc_sclk.
        if (phase_q && (half_q == '0) && (bit_q >= BW'(LEAD_BITS)))
          shift_d = {shift_q[ADC_BITS-2:0], adc_miso};
        if (half_last) begin
          half_d  = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_q == BW'(N - 1)) state_d = DONE;
            else                     bit_d   = bit_q + BW'(1);
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      DONE: begin
        state_d  = IDLE;
        sample_d = shift_q[ADC_BITS-1 -: D_WIDTH];
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin-level outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      half_q   <= '0;
      phase_q  <= 1'b0;
      bit_q    <= '0;
      shift_q  <= '0;
      sample_q <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      cs_n_q   <= !((state_q == CS_SETUP) || (state_q == SHIFT));
      sclk_q   <= (state_q == SHIFT) && phase_q;
      valid_q  <= (state_q == DONE);
      busy_q   <= (state_q != IDLE);
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mic_capture.sv
// Self-checking bench: behavioural ADC, per-cycle timing model, and directed scenarios.
module tb_mic_capture;

  localparam int D_WIDTH    = 8;
  localparam int ADC_BITS   = 12;
  localparam int LEAD_BITS  = 2;
  localparam int CLK_DIV    = 4;
  localparam int SAMPLE_DIV = 1000;
  localparam int N          = LEAD_BITS + ADC_BITS;
  localparam int LAT        = 1 + CLK_DIV + 2 * CLK_DIV * N;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               adc_miso = 1'b0;
  logic               adc_cs_n, adc_sclk, sample_valid, busy;
  logic [D_WIDTH-1:0] sample;

  mic_capture #(
    .D_WIDTH(D_WIDTH), .ADC_BITS(ADC_BITS), .LEAD_BITS(LEAD_BITS),
    .CLK_DIV(CLK_DIV), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .adc_miso     (adc_miso),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC: LEAD_BITS random bits then the 12-bit value MSB first, changing after sclk falls.
  logic [N-1:0]        frame;
  logic [ADC_BITS-1:0] plan_q[$];
  logic [ADC_BITS-1:0] conv_q[$];
  logic [ADC_BITS-1:0] last_adc;
  int                  bit_idx = 0;
  bit                  in_frame = 1'b0;

  initial begin
    forever begin
      @(negedge adc_cs_n or posedge adc_cs_n or negedge adc_sclk);
      #1;
      if (adc_cs_n === 1'b1) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        in_frame = 1'b1;
        bit_idx  = 0;
        last_adc = (plan_q.size() > 0) ? plan_q.pop_front() : ADC_BITS'($urandom);
        frame    = {LEAD_BITS'($urandom), last_adc};
        conv_q.push_back(last_adc);
      end else begin
        bit_idx++;
      end
      adc_miso = (in_frame && bit_idx < N) ? frame[N-1-bit_idx] : 1'($urandom);
    end
  end

  int rise_cnt = 0;
  always @(posedge adc_sclk or negedge adc_cs_n)
    if (adc_sclk === 1'b1) rise_cnt++;
    else                   rise_cnt = 0;

  int cs_fall_cnt = 0;
  int cs_fall_cyc = 0;
  always @(negedge adc_cs_n) begin
    cs_fall_cnt++;
    cs_fall_cyc = cyc;
  end

  // Model: rate count and conversion start edge; every output follows from the offset to it.
  int                 m_cnt = 0;
  int                 m_start = -1;
  logic [D_WIDTH-1:0] m_sample = '0;
  logic [ADC_BITS-1:0] m_val;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_cnt    = 0;
      m_start  = -1;
      m_sample = '0;
      conv_q.delete();
    end else begin
      if (m_cnt == SAMPLE_DIV - 1 && (m_start < 0 || cyc > m_start + LAT)) m_start = cyc;
      m_cnt = en ? (m_cnt + 1) % SAMPLE_DIV : 0;
      if (m_start >= 0 && cyc == m_start + LAT) begin
        if (conv_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL adc_frame: conversion ended with no ADC frame seen (cycle %0d)", cyc);
        end else begin
          m_val    = conv_q.pop_front();
          m_sample = m_val[ADC_BITS-1 -: D_WIDTH];
        end
      end
    end
  end

  int valid_cnt = 0;
  int last_valid_cyc = 0;

  always @(negedge clk) begin
    int   off, s;
    logic exp_sclk;
    off      = (m_start >= 0) ? cyc - m_start : -1;
    s        = off - (1 + CLK_DIV);
    exp_sclk = (off >= 1) && (s >= 0) && (s < 2 * CLK_DIV * N) && ((s % (2 * CLK_DIV)) >= CLK_DIV);
    check("cs_n",   32'(adc_cs_n),     32'(!(off >= 1 && off <= LAT - 1)));
    check("sclk",   32'(adc_sclk),     32'(exp_sclk));
    check("busy",   32'(busy),         32'(off >= 1 && off <= LAT));
    check("valid",  32'(sample_valid), 32'(off == LAT));
    check("sample", 32'(sample),       32'(m_sample));
    if (sample_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_cs_low(input string name, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (adc_cs_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  int prev_valid, vc, cf, en_cyc;

  initial begin
    #2 rst = 1'b0;
    #5;
    check("rst_cs_n",   32'(adc_cs_n),     32'd1);
    check("rst_sclk",   32'(adc_sclk),     32'd0);
    check("rst_sample", 32'(sample),       32'd0);
    check("rst_valid",  32'(sample_valid), 32'd0);
    check("rst_busy",   32'(busy),         32'd0);
    step(3);
    rst = 1'b1;

    // Disabled from reset: nothing happens.
    step(5000);
    check("idle_cs_falls", 32'(cs_fall_cnt), 32'd0);
    check("idle_valids",   32'(valid_cnt),   32'd0);

    // Fixed values, timing and period.
    plan_q = '{12'hABC, 12'hABC, 12'hFFF, 12'h000};
    en = 1'b1;
    wait_valid("to_first_valid", 1200);
    check("abc_sample",   32'(sample),   32'h0AB);
    check("sclk_rises",   32'(rise_cnt), 32'd14);
    check("cs_to_valid",  32'(last_valid_cyc - cs_fall_cyc), 32'd116);
    prev_valid = last_valid_cyc;
    wait_valid("to_second_valid", 1100);
    check("valid_period", 32'(last_valid_cyc - prev_valid), 32'd1000);
    check("abc_again",    32'(sample), 32'h0AB);
    wait_valid("to_fff_valid", 1100);
    check("fff_sample",   32'(sample), 32'h0FF);
    step(500);
    check("fff_hold",     32'(sample),   32'h0FF);
    check("cs_high_gap",  32'(adc_cs_n), 32'd1);
    wait_valid("to_000_valid", 600);
    check("zero_sample",  32'(sample), 32'h000);

    // Disable mid-conversion: it completes, then silence until re-enabled.
    wait_cs_low("cs_fall_before_disable", 1200);
    step(20);
    en = 1'b0;
    wait_valid("valid_after_disable", 200);
    vc = valid_cnt;
    cf = cs_fall_cnt;
    step(1500);
    check("no_valid_disabled", 32'(valid_cnt - vc),   32'd0);
    check("no_cs_disabled",    32'(cs_fall_cnt - cf), 32'd0);
    en = 1'b1;
    en_cyc = cyc;
    wait_valid("valid_after_reenable", 1300);
    check("reenable_latency", 32'(last_valid_cyc - en_cyc), 32'(SAMPLE_DIV + LAT));

    // Asynchronous reset in the middle of SHIFT.
    wait_cs_low("cs_fall_before_reset", 1200);
    step(40);
    check("mid_shift_cs_low", 32'(adc_cs_n), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_cs_n",   32'(adc_cs_n), 32'd1);
    check("async_rst_sclk",   32'(adc_sclk), 32'd0);
    check("async_rst_sample", 32'(sample),   32'd0);
    check("async_rst_busy",   32'(busy),     32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    plan_q.push_back(12'h5A3);
    wait_valid("valid_after_reset", 1300);
    check("post_reset_sample", 32'(sample), 32'h05A);

    // A few more random conversions for the per-cycle model.
    repeat (2) wait_valid("random_valid", 1100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
